// File: rtl/uio_pkg.sv
// +----------------------------------------------------------------------+
// | uio_pkg : shared user_io command bytes and SPI initiator state type  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package uio_pkg;

  localparam logic [7:0] CMD_KBD = 8'h05;
  localparam logic [7:0] CMD_STS = 8'h1E;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LOW   = 3'd2,
    HIGH  = 3'd3,
    GAPW  = 3'd4
  } state_e;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uio_spi_shift.sv
// +----------------------------------------------------------------------+
// | uio_spi_shift : 8-bit MSB-first shifter with bit counter / byte done |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module uio_spi_shift (
  input  logic       clock_i,
  input  logic       reset_ni,
  input  logic       load_i,
  input  logic       shift_i,
  input  logic [7:0] data_i,
  output logic       bit_o,
  output logic       done_o
);

  logic [7:0] sr_q, sr_d;
  logic [2:0] cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = data_i;
      cnt_d = 3'd0;
    end else if (shift_i) begin
      sr_d  = {sr_q[6:0], 1'b0};
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      sr_q  <= 8'h00;
      cnt_q <= 3'd0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign bit_o  = sr_q[7];
  assign done_o = (cnt_q == 3'd7);

endmodule

`default_nettype wire

// File: rtl/uio_spi_master.sv
// +----------------------------------------------------------------------+
// | uio_spi_master : serialises keyboard / status requests to user_io SPI|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module uio_spi_master #(
  parameter int         HALF    = 2,
  parameter int         GAP     = 4,
  parameter logic [7:0] CMD_KBD = 8'h05,
  parameter logic [7:0] CMD_STS = 8'h1E
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic        kbReq,
  input  logic [7:0]  kbData,
  input  logic        stReq,
  input  logic [31:0] stWord,
  output logic        busy,
  output logic        kbOvf,
  output logic        spiCk,
  output logic        spiSs,
  output logic        spiDo
);

  import uio_pkg::*;

  localparam int TW = $clog2(imax(HALF, GAP)) + 1;
  localparam logic [TW-1:0] C_HALF_END = TW'(HALF - 1);
  localparam logic [TW-1:0] C_GAP_END  = TW'(GAP - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          ck_q, ck_d;
  logic          ss_q, ss_d;
  logic [31:0]   rest_q, rest_d;
  logic [2:0]    byte_q, byte_d;
  logic          kb_v_q, kb_v_d;
  logic [7:0]    kb_data_q, kb_data_d;
  logic          st_v_q, st_v_d;
  logic [31:0]   st_word_q, st_word_d;
  logic          ovf_q, ovf_d;

  logic          sh_load, sh_shift, sh_bit, sh_done;
  logic [7:0]    sh_data;
  logic          ld_st, ld_kb;

  assign ld_st = ce && (state_q == IDLE) && st_v_q;
  assign ld_kb = ce && (state_q == IDLE) && !st_v_q && kb_v_q;

  uio_spi_shift u_shift (
    .clock_i  (clock),
    .reset_ni (reset),
    .load_i   (sh_load),
    .shift_i  (sh_shift),
    .data_i   (sh_data),
    .bit_o    (sh_bit),
    .done_o   (sh_done)
  );

  // Latches see the loaded source as empty, so a same-cycle request refills it.
  always_comb begin
    kb_v_d    = kb_v_q;
    kb_data_d = kb_data_q;
    ovf_d     = ovf_q;
    st_v_d    = st_v_q;
    st_word_d = st_word_q;
    if (ld_kb) kb_v_d = 1'b0;
    if (ld_st) st_v_d = 1'b0;
    if (kbReq) begin
      if (kb_v_d) begin
        ovf_d = 1'b1;
      end else begin
        kb_v_d    = 1'b1;
        kb_data_d = kbData;
      end
    end
    if (stReq) begin
      st_v_d    = 1'b1;
      st_word_d = stWord;
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    ck_d     = ck_q;
    ss_d     = ss_q;
    rest_d   = rest_q;
    byte_d   = byte_q;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_data  = rest_q[31:24];
    if (ce) begin
      case (state_q)
        IDLE: begin
          if (ld_st) begin
            sh_load = 1'b1;
            sh_data = CMD_STS;
            rest_d  = {st_word_q[7:0], st_word_q[15:8], st_word_q[23:16], st_word_q[31:24]};
            byte_d  = 3'd4;
          end else if (ld_kb) begin
            sh_load = 1'b1;
            sh_data = CMD_KBD;
            rest_d  = {kb_data_q, 24'h000000};
            byte_d  = 3'd1;
          end
          if (ld_st || ld_kb) begin
            ss_d    = 1'b0;
            tick_d  = '0;
            state_d = SETUP;
          end
        end
        SETUP: begin
          if (tick_q == C_HALF_END) begin
            tick_d  = '0;
            state_d = LOW;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        LOW: begin
          if (tick_q == C_HALF_END) begin
            tick_d  = '0;
            ck_d    = 1'b1;
            state_d = HIGH;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        HIGH: begin
          if (tick_q == C_HALF_END) begin
            tick_d = '0;
            ck_d   = 1'b0;
            if (!sh_done) begin
              sh_shift = 1'b1;
              state_d  = LOW;
            end else if (byte_q != 3'd0) begin
              sh_load = 1'b1;
              rest_d  = {rest_q[23:0], 8'h00};
              byte_d  = byte_q - 3'd1;
              state_d = LOW;
            end else begin
              ss_d    = 1'b1;
              state_d = GAPW;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        GAPW: begin
          if (tick_q == C_GAP_END) begin
            tick_d  = '0;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
        default: begin
          tick_d  = '0;
          ck_d    = 1'b0;
          ss_d    = 1'b1;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      ck_q      <= 1'b0;
      ss_q      <= 1'b1;
      rest_q    <= 32'h0;
      byte_q    <= 3'd0;
      kb_v_q    <= 1'b0;
      kb_data_q <= 8'h00;
      st_v_q    <= 1'b0;
      st_word_q <= 32'h0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      ck_q      <= ck_d;
      ss_q      <= ss_d;
      rest_q    <= rest_d;
      byte_q    <= byte_d;
      kb_v_q    <= kb_v_d;
      kb_data_q <= kb_data_d;
      st_v_q    <= st_v_d;
      st_word_q <= st_word_d;
      ovf_q     <= ovf_d;
    end
  end

  // The shifter only moves at a load or a falling edge, so MOSI is stable at rising edges.
  assign spiDo = sh_bit & ~ss_q;
  assign spiCk = ck_q;
  assign spiSs = ss_q;
  assign kbOvf = ovf_q;
  assign busy  = kb_v_q | st_v_q | (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uio_spi_master.sv
// +----------------------------------------------------------------------+
// | tb_uio_spi_master : tick-level SPI frame model and directed tests    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_uio_spi_master;

  localparam int HALF = 2;
  localparam int GAP  = 4;

  logic        clock  = 1'b0;
  logic        reset  = 1'b0;
  logic        ce     = 1'b1;
  logic        kbReq  = 1'b0;
  logic [7:0]  kbData = 8'h00;
  logic        stReq  = 1'b0;
  logic [31:0] stWord = 32'h0;
  logic        busy, kbOvf, spiCk, spiSs, spiDo;

  uio_spi_master #(
    .HALF    (HALF),
    .GAP     (GAP),
    .CMD_KBD (8'h05),
    .CMD_STS (8'h1E)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .ce     (ce),
    .kbReq  (kbReq),
    .kbData (kbData),
    .stReq  (stReq),
    .stWord (stWord),
    .busy   (busy),
    .kbOvf  (kbOvf),
    .spiCk  (spiCk),
    .spiSs  (spiSs),
    .spiDo  (spiDo)
  );

  always #5 clock = ~clock;

  int tot = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tot++;
    if (act !== req) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  // ce pacing: every cycle, or one cycle in four
  logic ce_slow = 1'b0;
  int   ce_ph   = 0;
  always @(negedge clock) begin
    if (ce_slow) begin
      ce_ph = (ce_ph + 1) % 4;
      ce    = (ce_ph == 0);
    end else begin
      ce = 1'b1;
    end
  end

  // Model: pending slots plus one frame described by its byte list and ticks since load.
  bit         m_kbv = 0, m_stv = 0, m_ovf = 0, m_active = 0;
  logic [7:0] m_kbd = 8'h00;
  logic [31:0] m_stw = 32'h0;
  logic [7:0] m_bytes [5];
  int         m_nb = 0, m_o = 0, m_total = 0;

  int   rises = 0, ss_low = 0, busy_cnt = 0, gap_run = 0, last_gap = 0;
  bit   cap [$];
  logic prev_ck = 1'b0, prev_do = 1'b0;

  logic e_ss, e_ck, e_do;
  int   bi, ph, u;

  always @(posedge clock) begin
    if (reset === 1'b0) begin
      m_kbv = 0; m_stv = 0; m_ovf = 0; m_active = 0; m_o = 0;
    end else begin
      if (ce === 1'b1) begin
        if (m_active) begin
          m_o++;
          if (m_o == m_total) m_active = 0;
        end else if (m_stv || m_kbv) begin
          if (m_stv) begin
            m_bytes[0] = 8'h1E; m_bytes[1] = m_stw[7:0]; m_bytes[2] = m_stw[15:8];
            m_bytes[3] = m_stw[23:16]; m_bytes[4] = m_stw[31:24];
            m_nb = 5; m_stv = 0;
          end else begin
            m_bytes[0] = 8'h05; m_bytes[1] = m_kbd; m_nb = 2; m_kbv = 0;
          end
          m_o = 0; m_active = 1;
          m_total = HALF + 16 * HALF * m_nb + GAP;
        end
      end
      if (kbReq) begin
        if (m_kbv) m_ovf = 1;
        else begin m_kbv = 1; m_kbd = kbData; end
      end
      if (stReq) begin m_stv = 1; m_stw = stWord; end
    end
    #1;
    e_ss = 1'b1; e_ck = 1'b0; e_do = 1'b0;
    if (m_active && m_o < HALF + 16 * HALF * m_nb) begin
      e_ss = 1'b0;
      if (m_o < HALF) begin bi = 0; ph = 0; end
      else begin u = m_o - HALF; bi = u / (2 * HALF); ph = u % (2 * HALF); end
      e_ck = (m_o >= HALF) && (ph >= HALF);
      e_do = m_bytes[bi / 8][7 - (bi % 8)];
    end
    chk("outputs{ss,ck,do,busy,ovf}", {spiSs, spiCk, spiDo, busy, kbOvf},
        {e_ss, e_ck, e_do, (m_kbv | m_stv | m_active), m_ovf});
    if (!prev_ck && spiCk) begin
      chk("do_stable_at_rise", spiDo, prev_do);
      if (!spiSs) begin rises++; cap.push_back(spiDo); end
    end
    if (!spiSs) ss_low++;
    if (busy) busy_cnt++;
    if (spiSs) gap_run++;
    else begin
      if (gap_run > 0) last_gap = gap_run;
      gap_run = 0;
    end
    prev_ck = spiCk;
    prev_do = spiDo;
  end

  function automatic logic [7:0] cap_byte(input int s, input int j);
    logic [7:0] b = 8'h00;
    for (int k = 0; k < 8; k++) b = {b[6:0], logic'(cap[s + 8 * j + k])};
    return b;
  endfunction

  task automatic send_kb(input logic [7:0] d);
    kbReq = 1'b1; kbData = d;
    @(negedge clock);
    kbReq = 1'b0;
  endtask

  task automatic send_st(input logic [31:0] w);
    stReq = 1'b1; stWord = w;
    @(negedge clock);
    stReq = 1'b0;
  endtask

  task automatic send_both(input logic [7:0] d, input logic [31:0] w);
    kbReq = 1'b1; kbData = d; stReq = 1'b1; stWord = w;
    @(negedge clock);
    kbReq = 1'b0; stReq = 1'b0;
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    @(negedge clock);
    while (busy !== 1'b0 && n < lim) begin
      @(negedge clock);
      n++;
    end
    chk("idle_reached", busy, 1'b0);
  endtask

  int s_r, s_c, s_ss, s_b;

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_state", {spiSs, spiCk, spiDo, busy, kbOvf}, 5'b10000);
    reset = 1'b1;
    @(negedge clock);

    // keyboard frame
    s_r = rises; s_c = cap.size(); s_ss = ss_low; s_b = busy_cnt;
    send_kb(8'h1C);
    wait_idle(300);
    chk("kb_rises", rises - s_r, 16);
    chk("kb_byte0", cap_byte(s_c, 0), 8'h05);
    chk("kb_byte1", cap_byte(s_c, 1), 8'h1C);
    chk("kb_ss_low_cycles", ss_low - s_ss, 66);
    chk("kb_busy_cycles", busy_cnt - s_b, 71);

    // status frame
    s_r = rises; s_c = cap.size();
    send_st(32'h0000_0023);
    wait_idle(500);
    chk("st_rises", rises - s_r, 40);
    chk("st_byte0", cap_byte(s_c, 0), 8'h1E);
    chk("st_byte1", cap_byte(s_c, 1), 8'h23);
    chk("st_byte2", cap_byte(s_c, 2), 8'h00);
    chk("st_byte3", cap_byte(s_c, 3), 8'h00);
    chk("st_byte4", cap_byte(s_c, 4), 8'h00);

    // simultaneous requests: status first
    s_r = rises; s_c = cap.size();
    send_both(8'h5A, 32'hA1B2_C3D4);
    wait_idle(800);
    chk("both_rises", rises - s_r, 56);
    chk("both_byte0", cap_byte(s_c, 0), 8'h1E);
    chk("both_byte1", cap_byte(s_c, 1), 8'hD4);
    chk("both_byte4", cap_byte(s_c, 4), 8'hA1);
    chk("both_byte5", cap_byte(s_c, 5), 8'h05);
    chk("both_byte6", cap_byte(s_c, 6), 8'h5A);
    chk("both_gap_ge_GAP", (last_gap >= GAP), 1'b1);

    // overflow: second keyboard byte during a frame is dropped
    s_r = rises; s_c = cap.size();
    send_kb(8'h11);
    repeat (10) @(negedge clock);
    send_kb(8'hF0);
    repeat (2) @(negedge clock);
    send_kb(8'h1C);
    chk("ovf_set", kbOvf, 1'b1);
    wait_idle(600);
    chk("ovf_rises", rises - s_r, 32);
    chk("ovf_byte1", cap_byte(s_c, 1), 8'h11);
    chk("ovf_byte3", cap_byte(s_c, 3), 8'hF0);
    chk("ovf_sticky", kbOvf, 1'b1);

    // reset mid-frame
    send_kb(8'h1C);
    repeat (20) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_mid_state", {spiSs, spiCk, spiDo, busy, kbOvf}, 5'b10000);
    reset = 1'b1;
    s_r = rises;
    repeat (50) @(negedge clock);
    chk("rst_no_edges", rises - s_r, 0);

    // ce one cycle in four
    ce_slow = 1'b1;
    repeat (4) @(negedge clock);
    s_r = rises; s_c = cap.size(); s_ss = ss_low;
    send_kb(8'h1C);
    wait_idle(1500);
    chk("slow_rises", rises - s_r, 16);
    chk("slow_byte0", cap_byte(s_c, 0), 8'h05);
    chk("slow_byte1", cap_byte(s_c, 1), 8'h1C);
    chk("slow_ss_low_cycles", ss_low - s_ss, 264);
    ce_slow = 1'b0;
    repeat (4) @(negedge clock);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uio_spi_master.md
Name: uio_spi_master

Overview:
- SPI initiator that drives the user_io command port (SPI_CLK / SPI_SS_IO / SPI_MOSI) from inside the FPGA.
- Used on boards with no control MCU, and as the bench driver for user_io.
- Serialises two transaction types into user_io SPI frames:
  - PS/2 keyboard bytes from a local keyboard front end.
  - 32-bit status words from a local on-screen menu.
- Sits beside the top level and feeds the same pins an external controller would drive.

Parameters:
- HALF, 2, number of ce ticks per SPI clock half-period (minimum 1).
- GAP, 4, number of ce ticks SS stays high between frames (minimum 1).
- CMD_KBD, 8'h05, command byte for a keyboard scancode frame.
- CMD_STS, 8'h1E, command byte for a 32-bit status frame.

Ports:
- clock  in  1  system clock (24 MHz domain).
- reset  in  1  synchronous, active-low reset; sampled on posedge clock.
- ce  in  1  clock enable; all state advances only when ce=1.
- kbReq  in  1  one-cycle strobe; kbData is valid in the same cycle.
- kbData  in  8  PS/2 scancode byte.
- stReq  in  1  one-cycle strobe; stWord is valid in the same cycle.
- stWord  in  32  status word.
- busy  out  1  high while a frame is pending or in flight.
- kbOvf  out  1  sticky flag; a kbReq was dropped. Cleared by reset only.
- spiCk  out  1  SPI clock; idles low.
- spiSs  out  1  chip select, active low; idles high.
- spiDo  out  1  MOSI.

Behaviour:
- Reset (reset=0 at a posedge clock): state=IDLE, spiCk=0, spiSs=1, spiDo=0, busy=0, kbOvf=0, both pending latches cleared. Reset mid-frame aborts the frame immediately; no partial byte is completed.
- Request latching: requests are captured on any clock cycle, independent of ce.
  - kbReq latches kbData into kbPend. If kbPend is already full, the new byte is dropped and kbOvf is set.
  - stReq latches stWord into stPend. A newer stReq overwrites an older pending word; only the latest status matters.
- busy = kbPend valid OR stPend valid OR state != IDLE.
- Frame formats, bytes sent MSB first:
  - Keyboard: CMD_KBD, kbData (2 bytes).
  - Status: CMD_STS, stWord[7:0], [15:8], [23:16], [31:24] (5 bytes).
- Arbitration in IDLE: status wins over keyboard if both are pending. The chosen pending latch is cleared when the frame is loaded.
- FSM (each "tick" is one ce=1 cycle):
  - IDLE: if anything is pending, load the shift register and byte count, drive spiSs=0, and go to SETUP.
  - SETUP: wait HALF ticks with spiDo = bit7 of byte0, then go to LOW.
  - LOW: spiCk=0 for HALF ticks, then spiCk rises and the state goes to HIGH. The receiver samples on this rising edge.
  - HIGH: spiCk=1 for HALF ticks, then spiCk falls.
    - If bits remain, shift and present the next bit on the falling edge, then go to LOW.
    - Otherwise go to GAPW.
  - GAPW: spiCk=0, spiSs=1, wait GAP ticks, then go to IDLE.
- Timing: one bit takes 2*HALF ticks. A full frame takes HALF + 16*HALF*bytes + GAP ticks: HALF=2, GAP=4 gives 70 ticks for keyboard and 166 for status.
- spiDo changes only while spiCk is low or at its falling edge, never at a rising edge.
- A frame is never interrupted by new requests; they wait in the latches.
- Counters:
  - Tick counter is width $clog2(max(HALF,GAP))+1 and wraps to 0 on every state/phase change.
  - Bit counter is 3 bits.
  - Byte counter is 3 bits and counts down to 0.
- Requests arriving in the same cycle the FSM loads a frame:
  - For a source that is not being loaded, the request latches normally.
  - For the source being loaded, the new request re-fills that latch, so it is not lost and does not set kbOvf.
- ce=0 freezes all outputs and counters.

Decomposition:
- Package uio_pkg: constants CMD_KBD, CMD_STS, and the state enum {IDLE, SETUP, LOW, HIGH, GAPW}. The package is shared with any future user_io bench code.
- One natural sub-module, uio_spi_shift: an 8-bit MSB-first shifter with bit counter and byte-done output.
- Frame sequencing and arbitration stay in uio_spi_master.

Test Plan:
- Reset held low for 3 cycles mid-frame -> spiSs=1, spiCk=0, spiDo=0, busy=0 on the cycle after reset is sampled; no further spiCk edges.
- kbReq with kbData=8'h1C, HALF=2, GAP=4, ce=1 -> SPI monitor decodes 16 bits 0x05,0x1C on spiCk rising edges; spiSs low for 66 cycles; busy falls 70 cycles after loading.
- stReq with stWord=32'h0000_0023 -> bytes 0x1E,0x23,0x00,0x00,0x00; exactly 40 rising edges of spiCk.
- kbReq and stReq in the same cycle -> status frame first, then keyboard frame, separated by at least GAP ticks with spiSs=1.
- During a frame, two kbReq (8'hF0 then 8'h1C) -> second is dropped, kbOvf=1; after the current frame, a frame carrying 0xF0 follows.
- ce pulsed 1-in-4 -> the same bit sequence as the ce=1 run, with every interval stretched ×4; no spiDo transition coincides with a rising spiCk edge.
